mix_ti_cic_interp_8x2p: RTL and testbench
=========================================

Name: mix_ti_cic_interp_8x2p

Overview:
Transmit-side counterpart of the mixed, time-interleaved CIC decimator. It takes baseband samples through a valid/ready handshake and interpolates them by 8 with a 2-stage CIC (M=1). It then up-mixes each sample by the fs/4 sign pattern +1,-1,-1,+1 and de-interleaves the result onto four parallel DAC lanes OUT1..OUT4, with a frame strobe.

Parameters:
BW, 6, input sample width (signed)
R, 8, interpolation ratio (fixed; the 8-cycle phase counter depends on it)
N, 2, CIC stage count (fixed)

Ports:
CLK  in  1  single clock, runs at the high (interpolated) sample rate
RES  in  1  reset; synchronous, active-high
ENABLE  in  1  advances all state when high; freezes all state when low
IN  in  BW  signed baseband sample
IN_VALID  in  1  IN holds a valid sample
IN_READY  out  1  block accepts IN this cycle
OUT1..OUT4  out  BW+4 each  signed mixed lane samples; lane k carries mixer phase k-1
OUT_VALID  out  1  one-cycle pulse; OUT1..OUT4 hold a new frame
UNDERFLOW  out  1  sticky flag; present only with the optional feature, else tied 0

Behaviour:
- Reset (RES high at a CLK edge) clears:
  - 3-bit phase counter cnt
  - comb delay registers
  - both integrators
  - lane buffer
  - all outputs, including IN_READY and UNDERFLOW
- ENABLE low:
  - every register holds its value
  - IN_READY=0, OUT_VALID=0
- cnt increments mod 8 on each enabled cycle.
- Input acceptance:
  - IN_READY = ENABLE & (cnt==7).
  - A transfer occurs when IN_VALID & IN_READY.
  - If IN_VALID=0 at cnt==7, the comb stage is fed 0 for that slot (underflow).
- Comb stage (low rate, updates only on the cnt==7 cycle):
  - c = x - 2·x[-1] + x[-2]
  - width BW+3
  - registered output is visible at cnt==0
- Zero-stuffing and integrators:
  - Integrator 1 input = comb output when cnt==0, else 0.
  - Integrator 2 accumulates integrator 1 output.
  - Each integrator is one register stage, width BW+3, two's-complement wrap (modular arithmetic is correct for CIC).
- Gain: DC gain is R^(N-1) = 8. The impulse response is the triangle 1,2,…,8,7,…,1.
- Mixer and lane assignment:
  - The integrator 2 value visible in a cycle with cnt=c goes to lane ((c-2) mod 4)+1.
  - Mixer sign per lane: 1:+, 2:-, 3:-, 4:+.
  - Sign is applied after sign extension to BW+4, so negating -2^(BW+2) cannot overflow.
  - The lane buffer captures at the end of that cycle.
- OUT_VALID:
  - Pulses in the cycle after lane 4 is captured, i.e. cnt==6 and cnt==2 (two frames per input sample).
  - OUT1..OUT4 update together and are stable between pulses.
- Latency: a sample accepted in cycle t (cnt=7) first contributes to lane 1 of the frame flagged at cycle t+7.
- Reset mid-operation: immediate return to reset state. The next acceptance is at the first cnt==7 after release.

Optional Feature:
MIX_CIC_INTERP_UFLOW_EN
- Defined:
  - UNDERFLOW sets on any cnt==7 enabled cycle with IN_VALID=0.
  - It stays set until RES.
- Undefined:
  - No detection logic is built.
  - UNDERFLOW is tied 0.
- Zero-insertion happens in both cases.

Decomposition:
- Package mix_cic_interp_pkg holds:
  - constants R=8, N=2
  - gain bit growth GROWTH=3
  - mixer sign table {+1,-1,-1,+1}
  - lane-offset constant 2
- Sub-module cic_interp_core holds the comb, zero-stuff and two integrators.
  - Inputs: sample, load strobe, cnt==0 flag.
  - Output: BW+3 serial high-rate sample.
- The top holds cnt, the handshake, the mixer, the lane buffer and the feature logic.

Test Plan:
- Reset/idle: RES high 3 cycles, then ENABLE=1, IN_VALID=0 → IN_READY pulses every 8 cycles; all OUTx=0; OUT_VALID pulses at cnt 6 and 2.
- Impulse: IN=1 accepted once at t, then zeros → frames at t+7, t+11, t+15, t+19 are (1,-2,-3,4), (5,-6,-7,8), (7,-6,-5,4), (3,-2,-1,0).
- DC: IN=1 continuously → steady frame (8,-8,-8,8).
- Extreme: BW=6, IN=-32 continuously → steady frame (-256,256,256,-256), no wrap on lanes 2/3.
- Handshake/ENABLE: drop ENABLE for 5 cycles mid-frame → cnt, integrators and OUTx frozen; IN_READY=0; output sequence resumes unshifted. Hold IN_VALID=0 at one cnt==7 → zero inserted; UNDERFLOW=1 with MIX_CIC_INTERP_UFLOW_EN, 0 without.
- Mid-run reset: RES during the DC test → next cycle all OUTx=0, UNDERFLOW=0; DC frame is re-established after the integrators settle.

Source files
------------

// File: rtl/mix_cic_interp_pkg.sv
// Shared constants for the fs/4-mixed, lane-interleaved 2-stage CIC interpolator.
package mix_cic_interp_pkg;

    localparam int CIC_R  = 8;
    localparam int CIC_N  = 2;
    localparam int GROWTH = 3;
    localparam int LANES  = 4;

    // fs/4 up-mix pattern; entry k is the sign applied to lane k+1.
    localparam int MIX_SIGN [LANES] = '{1, -1, -1, 1};

    // Integrator output visible at cnt=c belongs to lane ((c - LANE_OFFSET) mod 4) + 1.
    localparam logic [1:0] LANE_OFFSET = 2'd2;

endpackage

// File: rtl/cic_interp_core.sv
// Comb, zero-stuffer and two integrators of the R=8, N=2, M=1 CIC interpolator.
module cic_interp_core
    import mix_cic_interp_pkg::*;
#(
    parameter int BW = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic signed [BW-1:0]        sample_i,
    input  logic                        load_i,
    input  logic                        zero_phase_i,
    output logic signed [BW+GROWTH-1:0] y_o
);

    localparam int W = BW + GROWTH;

    logic signed [BW-1:0] x1_q, x2_q;
    logic signed [W-1:0]  comb_d, comb_q;
    logic signed [W-1:0]  int1_d, int1_q;
    logic signed [W-1:0]  int2_d, int2_q;
    logic signed [W-1:0]  x0_ext, x1_ext, x2_ext;

    // Low-rate comb pair collapses to the second difference x - 2x[-1] + x[-2].
    always_comb begin
        x0_ext = {{GROWTH{sample_i[BW-1]}}, sample_i};
        x1_ext = {{GROWTH{x1_q[BW-1]}}, x1_q};
        x2_ext = {{GROWTH{x2_q[BW-1]}}, x2_q};
        comb_d = x0_ext - (x1_ext <<< 1) + x2_ext;
        int1_d = int1_q + (zero_phase_i ? comb_q : '0);
        int2_d = int2_q + int1_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x1_q   <= '0;
            x2_q   <= '0;
            comb_q <= '0;
            int1_q <= '0;
            int2_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                x1_q   <= sample_i;
                x2_q   <= x1_q;
                comb_q <= comb_d;
            end
            int1_q <= int1_d;
            int2_q <= int2_d;
        end
    end

    assign y_o = int2_q;

endmodule

// File: rtl/mix_ti_cic_interp_8x2p.sv
// Interpolate-by-8 CIC, fs/4 up-mixer and 4-lane DAC de-interleaver with frame strobe.
// Optional sticky underflow detection is built when MIX_CIC_INTERP_UFLOW_EN is defined.
module mix_ti_cic_interp_8x2p
    import mix_cic_interp_pkg::*;
#(
    parameter int BW = 6,
    parameter int R  = 8,
    parameter int N  = 2
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 ENABLE,
    input  logic signed [BW-1:0] IN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic signed [BW+3:0] OUT1,
    output logic signed [BW+3:0] OUT2,
    output logic signed [BW+3:0] OUT3,
    output logic signed [BW+3:0] OUT4,
    output logic                 OUT_VALID,
    output logic                 UNDERFLOW
);

    localparam int CNT_W = $clog2(R);
    localparam int YW    = BW + (N - 1) * $clog2(R);
    localparam int OW    = BW + 4;

    // Extend before negating so -2^(YW-1) maps to +2^(YW-1) without wrap.
    function automatic logic signed [OW-1:0] mix_lane(input logic signed [YW-1:0] y,
                                                      input logic [1:0] lane);
        logic signed [OW-1:0] ext;
        ext = {{(OW - YW){y[YW-1]}}, y};
        return (MIX_SIGN[lane] < 0) ? -ext : ext;
    endfunction

    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic                 last_slot;
    logic                 load;
    logic signed [BW-1:0] sample;
    logic signed [YW-1:0] y;
    logic [1:0]           lane_idx;
    logic signed [OW-1:0] mixed;
    logic signed [OW-1:0] stage_d [3];
    logic signed [OW-1:0] stage_q [3];
    logic signed [OW-1:0] out_d   [LANES];
    logic signed [OW-1:0] out_q   [LANES];

    assign last_slot = (cnt_q == CNT_W'(R - 1));
    assign load      = ENABLE & last_slot;
    assign IN_READY  = load;
    assign sample    = IN_VALID ? IN : '0;
    assign OUT_VALID = ENABLE & (cnt_q[1:0] == 2'b10);

    cic_interp_core #(.BW(BW)) u_core (
        .clk_i        (CLK),
        .rst_i        (RES),
        .en_i         (ENABLE),
        .sample_i     (sample),
        .load_i       (load),
        .zero_phase_i (cnt_q == '0),
        .y_o          (y)
    );

    // Lanes 1-3 wait in a staging buffer; lane 4 releases the whole frame at once.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        lane_idx = cnt_q[1:0] - LANE_OFFSET;
        mixed    = mix_lane(y, lane_idx);
        stage_d  = stage_q;
        out_d    = out_q;
        case (lane_idx)
            2'd0: stage_d[0] = mixed;
            2'd1: stage_d[1] = mixed;
            2'd2: stage_d[2] = mixed;
            default: begin
                out_d[0] = stage_q[0];
                out_d[1] = stage_q[1];
                out_d[2] = stage_q[2];
                out_d[3] = mixed;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            cnt_q <= '0;
            for (int i = 0; i < 3; i++) stage_q[i] <= '0;
            for (int i = 0; i < LANES; i++) out_q[i] <= '0;
        end else if (ENABLE) begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
        end
    end

    assign OUT1 = out_q[0];
    assign OUT2 = out_q[1];
    assign OUT3 = out_q[2];
    assign OUT4 = out_q[3];

`ifdef MIX_CIC_INTERP_UFLOW_EN
    logic uflow_d, uflow_q;

    assign uflow_d = uflow_q | (load & ~IN_VALID);

    always_ff @(posedge CLK) begin
        if (RES) begin
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign UNDERFLOW = uflow_q;
`else
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_mix_ti_cic_interp_8x2p.sv
// Scoreboard bench: triangle-impulse convolution model of the 8x CIC plus fs/4 mixing.
module tb_mix_ti_cic_interp_8x2p;

    localparam int BW = 6;
    localparam int OW = BW + 4;

    logic                 clk = 1'b0;
    logic                 RES = 1'b1;
    logic                 ENABLE = 1'b0;
    logic                 IN_VALID = 1'b0;
    logic signed [BW-1:0] IN = '0;
    logic                 IN_READY;
    logic signed [OW-1:0] OUT1, OUT2, OUT3, OUT4;
    logic                 OUT_VALID;
    logic                 UNDERFLOW;

    always #5 clk = ~clk;

    mix_ti_cic_interp_8x2p #(.BW(BW), .R(8), .N(2)) dut (
        .CLK       (clk),
        .RES       (RES),
        .ENABLE    (ENABLE),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT1      (OUT1),
        .OUT2      (OUT2),
        .OUT3      (OUT3),
        .OUT4      (OUT4),
        .OUT_VALID (OUT_VALID),
        .UNDERFLOW (UNDERFLOW)
    );

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int xs[$];
    int e = 0;
    bit uf_model = 1'b0;
    bit post_reset = 1'b0;
    int sgn [4] = '{1, -1, -1, 1};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Impulse response of the 2-stage interpolate-by-8 CIC: 1..8..1.
    function automatic int h(input int k);
        if (k < 0 || k > 14) return 0;
        return (k < 8) ? k + 1 : 15 - k;
    endfunction

    // High-rate value presented at enabled cycle n (cycles counted from reset release);
    // slot j is accepted at cycle 8j+7 and reaches the lane path three cycles later.
    function automatic int y_at(input int n);
        int s = 0;
        foreach (xs[j]) s += xs[j] * h(n - 8 * j - 10);
        return s;
    endfunction

    task automatic cyc(input bit res, input bit en, input bit v, input int din);
        int exp_uf;
        @(posedge clk);
        #1;
        RES      = res;
        ENABLE   = en;
        IN_VALID = v;
        IN       = BW'(din);
        #1;
        if (res) begin
            e = 0;
            xs.delete();
            uf_model = 1'b0;
            post_reset = 1'b1;
        end else begin
            if (post_reset) begin
                chk("rst_out1", int'(OUT1), 0);
                chk("rst_out2", int'(OUT2), 0);
                chk("rst_out3", int'(OUT3), 0);
                chk("rst_out4", int'(OUT4), 0);
                post_reset = 1'b0;
            end
            chk("in_ready", int'(IN_READY), (en && (e % 8 == 7)) ? 1 : 0);
`ifdef MIX_CIC_INTERP_UFLOW_EN
            exp_uf = uf_model ? 1 : 0;
`else
            exp_uf = 0;
`endif
            chk("underflow", int'(UNDERFLOW), exp_uf);
            if (en) begin
                if (e % 4 == 2) begin
                    for (int l = 0; l < 4; l++) exp_q.push_back(sgn[l] * y_at(e - 4 + l));
                end
                if (e % 8 == 7) begin
                    xs.push_back(v ? din : 0);
                    if (!v) uf_model = 1'b1;
                end
                e++;
            end
        end
    endtask

    // Monitor: every frame strobe outside reset consumes one expected frame.
    initial begin
        int act [4];
        forever begin
            @(negedge clk);
            if (!RES && OUT_VALID) begin
                act[0] = int'(OUT1);
                act[1] = int'(OUT2);
                act[2] = int'(OUT3);
                act[3] = int'(OUT4);
                if (exp_q.size() < 4) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=strobe required=none (t=%0t)", $time);
                end else begin
                    for (int l = 0; l < 4; l++) chk($sformatf("lane%0d", l + 1), act[l], exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 0);
        // Idle: no valid input, zero frames, underflow slots.
        repeat (24) cyc(1'b0, 1'b1, 1'b0, 0);
        // Impulse of 1 in the first slot, then zeros.
        cyc(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 48; i++) cyc(1'b0, 1'b1, 1'b1, (i < 8) ? 1 : 0);
        // DC and negative full scale.
        repeat (64) cyc(1'b0, 1'b1, 1'b1, 1);
        repeat (64) cyc(1'b0, 1'b1, 1'b1, -32);
        // ENABLE dropped for 5 cycles mid-frame.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 5);
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 5);
        repeat (24) cyc(1'b0, 1'b1, 1'b1, -7);
        // Randomised samples, valid gaps and enable gaps.
        for (int i = 0; i < 400; i++) begin
            bit en, v;
            int din;
            en  = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 7) != 0);
            din = int'($urandom_range(0, 63)) - 32;
            cyc(1'b0, en, v, din);
        end
        // Mid-run reset during DC.
        repeat (40) cyc(1'b0, 1'b1, 1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 1);
        repeat (64) cyc(1'b0, 1'b1, 1'b1, 1);
        repeat (8) cyc(1'b0, 1'b1, 1'b1, 0);
        @(negedge clk);
        #1;
        chk("frames_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
